// File: rtl/ex_mem_reg.sv
// ----------------------------------------------------------------------------
// ex_mem_reg
//   EX->MEM pipeline register of the 5-stage MIPS core. It carries the GPR
//   write and the HI/LO write from EX into MEM and applies the control
//   unit's stall and flush requests.
//
//   A two-cycle madd/msub that is stalled in EX needs somewhere to keep its
//   partial 64-bit product and its cycle count. This register holds them
//   while EX is stalled and returns them to EX on the following cycle.
//
// Ports
//   clk, rst_n       rising-edge clock; synchronous active-low reset
//   stall            per-stage stall vector (bit k = stage k held;
//                    0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB)
//   flush            squashes the in-flight result (exception / branch)
//   ex_*             EX-stage results: GPR addr/data/en, HI/LO/wen,
//                    madd/msub partial product and cycle count
//   mem_*            registered results to MEM; mem_valid = 0 is a bubble
//   hilo_temp_out    parked madd/msub partial product returned to EX
//   cnt_out          parked madd/msub cycle count returned to EX
// ----------------------------------------------------------------------------
module ex_mem_reg #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 32,
    parameter int STALL_WIDTH    = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [STALL_WIDTH-1:0]      stall,
    input  logic                        flush,
    input  logic [REG_ADDR_WIDTH-1:0]   ex_w_reg_addr,
    input  logic [REG_DATA_WIDTH-1:0]   ex_w_reg_data,
    input  logic                        ex_w_reg_en,
    input  logic [REG_DATA_WIDTH-1:0]   ex_hi,
    input  logic [REG_DATA_WIDTH-1:0]   ex_lo,
    input  logic                        ex_hilo_wen,
    input  logic [2*REG_DATA_WIDTH-1:0] ex_hilo_temp,
    input  logic [1:0]                  ex_cnt,
    output logic [REG_ADDR_WIDTH-1:0]   mem_w_reg_addr,
    output logic [REG_DATA_WIDTH-1:0]   mem_w_reg_data,
    output logic                        mem_w_reg_en,
    output logic [REG_DATA_WIDTH-1:0]   mem_hi,
    output logic [REG_DATA_WIDTH-1:0]   mem_lo,
    output logic                        mem_hilo_wen,
    output logic                        mem_valid,
    output logic [2*REG_DATA_WIDTH-1:0] hilo_temp_out,
    output logic [1:0]                  cnt_out
);

    typedef enum logic [1:0] {
        MODE_ADVANCE,   // EX moves on: capture its result
        MODE_BUBBLE,    // EX held, MEM free: insert a bubble, park madd/msub state
        MODE_HOLD       // MEM held: keep everything
    } mode_t;

    mode_t mode;

    // Only the EX and MEM bits of the stall vector affect this stage.
    // The other bits are reduced into a single sink signal that nothing reads.
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_WIDTH-1:5], stall[2:0]};

    // NOTE: every variable written in always_comb gets a default first so
    // that no path leaves it unassigned; otherwise a latch would be inferred.
    always_comb begin
        mode = MODE_HOLD;
        if (!stall[3] && !stall[4]) begin
            mode = MODE_ADVANCE;
        end else if (stall[3] && !stall[4]) begin
            mode = MODE_BUBBLE;
        end
        // If EX advances while MEM is stalled (S3=0, S4=1), control has made
        // an error. Treating it as HOLD means the stalled MEM instruction is
        // not overwritten.
    end

    // NOTE: state registers use non-blocking assignments so that all flops
    // sample their inputs from the same edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            // Reset and flush clear the same state. A flush also drops any
            // parked madd/msub, so EX restarts that instruction from cnt=0.
            mem_w_reg_addr <= '0;
            mem_w_reg_data <= '0;
            mem_w_reg_en   <= 1'b0;
            mem_hi         <= '0;
            mem_lo         <= '0;
            mem_hilo_wen   <= 1'b0;
            mem_valid      <= 1'b0;
            hilo_temp_out  <= '0;
            cnt_out        <= '0;
        end else begin
            unique case (mode)
                MODE_ADVANCE: begin
                    mem_w_reg_addr <= ex_w_reg_addr;
                    mem_w_reg_data <= ex_w_reg_data;
                    mem_w_reg_en   <= ex_w_reg_en;
                    mem_hi         <= ex_hi;
                    mem_lo         <= ex_lo;
                    mem_hilo_wen   <= ex_hilo_wen;
                    mem_valid      <= 1'b1;
                    hilo_temp_out  <= '0;
                    cnt_out        <= '0;
                end
                MODE_BUBBLE: begin
                    // A bubble never writes, whatever EX is currently driving.
                    mem_w_reg_addr <= '0;
                    mem_w_reg_data <= '0;
                    mem_w_reg_en   <= 1'b0;
                    mem_hi         <= '0;
                    mem_lo         <= '0;
                    mem_hilo_wen   <= 1'b0;
                    mem_valid      <= 1'b0;
                    // Plain copy of the madd/msub state. An ex_cnt of 3 is
                    // passed through unchanged.
                    hilo_temp_out  <= ex_hilo_temp;
                    cnt_out        <= ex_cnt;
                end
                default: begin
                    // HOLD: all outputs keep their values. The illegal
                    // combination EX-advance/MEM-stall also lands here.
                    assert (stall[3]);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_reg
//   Directed bench for ex_mem_reg. Inputs change shortly after a rising edge.
//   Outputs are sampled 1 time unit after the following rising edge and
//   compared against values worked out by hand.
// ----------------------------------------------------------------------------
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_w_reg_addr;
    logic [31:0] ex_w_reg_data;
    logic        ex_w_reg_en;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_hilo_wen;
    logic [63:0] ex_hilo_temp;
    logic [1:0]  ex_cnt;
    logic [4:0]  mem_w_reg_addr;
    logic [31:0] mem_w_reg_data;
    logic        mem_w_reg_en;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_hilo_wen;
    logic        mem_valid;
    logic [63:0] hilo_temp_out;
    logic [1:0]  cnt_out;

    int checks   = 0;
    int failures = 0;

    ex_mem_reg dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .ex_w_reg_addr  (ex_w_reg_addr),
        .ex_w_reg_data  (ex_w_reg_data),
        .ex_w_reg_en    (ex_w_reg_en),
        .ex_hi          (ex_hi),
        .ex_lo          (ex_lo),
        .ex_hilo_wen    (ex_hilo_wen),
        .ex_hilo_temp   (ex_hilo_temp),
        .ex_cnt         (ex_cnt),
        .mem_w_reg_addr (mem_w_reg_addr),
        .mem_w_reg_data (mem_w_reg_data),
        .mem_w_reg_en   (mem_w_reg_en),
        .mem_hi         (mem_hi),
        .mem_lo         (mem_lo),
        .mem_hilo_wen   (mem_hilo_wen),
        .mem_valid      (mem_valid),
        .hilo_temp_out  (hilo_temp_out),
        .cnt_out        (cnt_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Let one rising edge pass, then sample away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".addr"},  64'(mem_w_reg_addr), 64'd0);
        check({tag, ".data"},  64'(mem_w_reg_data), 64'd0);
        check({tag, ".en"},    64'(mem_w_reg_en),   64'd0);
        check({tag, ".hi"},    64'(mem_hi),         64'd0);
        check({tag, ".lo"},    64'(mem_lo),         64'd0);
        check({tag, ".wen"},   64'(mem_hilo_wen),   64'd0);
        check({tag, ".valid"}, 64'(mem_valid),      64'd0);
        check({tag, ".temp"},  hilo_temp_out,       64'd0);
        check({tag, ".cnt"},   64'(cnt_out),        64'd0);
    endtask

    initial begin
        // 1: reset with every input driven to ones
        rst_n = 1'b0; stall = '1; flush = 1'b1;
        ex_w_reg_addr = '1; ex_w_reg_data = '1; ex_w_reg_en = 1'b1;
        ex_hi = '1; ex_lo = '1; ex_hilo_wen = 1'b1;
        ex_hilo_temp = '1; ex_cnt = '1;
        step();
        check_all_zero("reset");

        // 2: advance
        rst_n = 1'b1; flush = 1'b0; stall = 6'b000000;
        ex_w_reg_addr = 5'd9; ex_w_reg_data = 32'hDEADBEEF; ex_w_reg_en = 1'b1;
        ex_hi = 32'h1111_1111; ex_lo = 32'h2222_2222; ex_hilo_wen = 1'b1;
        ex_hilo_temp = 64'h0123_4567_89AB_CDEF; ex_cnt = 2'd2;
        step();
        check("adv.addr",  64'(mem_w_reg_addr), 64'd9);
        check("adv.data",  64'(mem_w_reg_data), 64'hDEADBEEF);
        check("adv.en",    64'(mem_w_reg_en),   64'd1);
        check("adv.hi",    64'(mem_hi),         64'h1111_1111);
        check("adv.lo",    64'(mem_lo),         64'h2222_2222);
        check("adv.wen",   64'(mem_hilo_wen),   64'd1);
        check("adv.valid", 64'(mem_valid),      64'd1);
        check("adv.cnt",   64'(cnt_out),        64'd0);
        check("adv.temp",  hilo_temp_out,       64'd0);

        // 3: madd park. EX still asserts its enables, but the bubble must not write.
        stall = 6'b001111; ex_cnt = 2'd1;
        ex_hilo_temp = 64'h0000_0001_FFFF_FFFE;
        step();
        check("park.cnt",   64'(cnt_out),        64'd1);
        check("park.temp",  hilo_temp_out,       64'h0000_0001_FFFF_FFFE);
        check("park.en",    64'(mem_w_reg_en),   64'd0);
        check("park.wen",   64'(mem_hilo_wen),   64'd0);
        check("park.valid", 64'(mem_valid),      64'd0);
        check("park.addr",  64'(mem_w_reg_addr), 64'd0);
        check("park.data",  64'(mem_w_reg_data), 64'd0);

        stall = 6'b000000;
        step();
        check("unpark.cnt",   64'(cnt_out),        64'd0);
        check("unpark.temp",  hilo_temp_out,       64'd0);
        check("unpark.valid", 64'(mem_valid),      64'd1);
        check("unpark.data",  64'(mem_w_reg_data), 64'hDEADBEEF);

        // Boundary: ex_cnt=3 and a full-width partial product are copied unchanged
        stall = 6'b001111; ex_cnt = 2'd3;
        ex_hilo_temp = 64'hFEDC_BA98_7654_3210;
        step();
        check("cnt3.cnt",  64'(cnt_out),  64'd3);
        check("cnt3.temp", hilo_temp_out, 64'hFEDC_BA98_7654_3210);

        // 4: load A, then hold for 3 edges while the EX inputs change
        stall = 6'b000000; ex_cnt = 2'd0;
        ex_w_reg_addr = 5'd3; ex_w_reg_data = 32'hA5A5_A5A5; ex_w_reg_en = 1'b1;
        ex_hi = 32'h0BAD_0001; ex_lo = 32'h0BAD_0002; ex_hilo_wen = 1'b1;
        step();
        check("loadA.data", 64'(mem_w_reg_data), 64'hA5A5_A5A5);
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            ex_w_reg_addr = 5'(20 + i); ex_w_reg_data = 32'(i) * 32'h0101_0101;
            ex_w_reg_en = 1'b0; ex_hi = 32'(i); ex_lo = 32'(i + 7);
            ex_hilo_wen = 1'b0; ex_cnt = 2'd2; ex_hilo_temp = 64'(i + 1);
            step();
            check("hold.addr",  64'(mem_w_reg_addr), 64'd3);
            check("hold.data",  64'(mem_w_reg_data), 64'hA5A5_A5A5);
            check("hold.en",    64'(mem_w_reg_en),   64'd1);
            check("hold.hi",    64'(mem_hi),         64'h0BAD_0001);
            check("hold.lo",    64'(mem_lo),         64'h0BAD_0002);
            check("hold.wen",   64'(mem_hilo_wen),   64'd1);
            check("hold.valid", 64'(mem_valid),      64'd1);
            check("hold.cnt",   64'(cnt_out),        64'd0);
        end

        // 5: flush takes priority over the hold
        flush = 1'b1;
        step();
        check_all_zero("flush");
        flush = 1'b0;

        // 6: reset while madd/msub state is parked
        stall = 6'b001111; ex_cnt = 2'd2;
        ex_hilo_temp = 64'h0000_0001_FFFF_FFFE;
        step();
        check("park2.cnt",  64'(cnt_out),  64'd2);
        check("park2.temp", hilo_temp_out, 64'h0000_0001_FFFF_FFFE);
        rst_n = 1'b0;
        step();
        check_all_zero("rstpark");
        rst_n = 1'b1; stall = 6'b000000; ex_cnt = 2'd0;
        ex_w_reg_addr = 5'd7; ex_w_reg_data = 32'h1234_5678; ex_w_reg_en = 1'b1;
        ex_hi = 32'hCAFE_0000; ex_lo = 32'h0000_CAFE; ex_hilo_wen = 1'b0;
        step();
        check("resume.addr",  64'(mem_w_reg_addr), 64'd7);
        check("resume.data",  64'(mem_w_reg_data), 64'h1234_5678);
        check("resume.hi",    64'(mem_hi),         64'hCAFE_0000);
        check("resume.wen",   64'(mem_hilo_wen),   64'd0);
        check("resume.valid", 64'(mem_valid),      64'd1);
        check("resume.cnt",   64'(cnt_out),        64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
